sample_scheduler: RTL and testbench

Sequences training samples through the backpropagation datapath. It issues sample indices to the forward pass, replays the same indices in order to the error fetcher's target lookup, and bounds the number of samples in flight. It counts retired deltas to detect epoch and run completion. It sits between the top-level training control and the forward-pass and error-fetcher sample ports.

---
 rtl/sample_scheduler_pkg.sv | 15 +
 rtl/sample_scheduler_index_fifo.sv | 47 ++++
 rtl/sample_scheduler.sv | 132 +++++++++++++
 tb/tb_sample_scheduler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sample_scheduler_pkg.sv
// sample_scheduler_pkg: shared state encoding and counter sizing for the sample scheduler.
package sample_scheduler_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam int MAX_INFLIGHT_DEFAULT = 4;

    // One extra bit so the counter can hold the full depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int OUT_CNT_W = cnt_width(MAX_INFLIGHT_DEFAULT);

endpackage

// File: rtl/sample_scheduler_index_fifo.sv
// index_fifo: in-order synchronous FIFO of sample indices with valid/ready on both sides.
module index_fifo
    import sample_scheduler_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             push, pop;

    assign in_ready_o  = cnt_q != CW'(DEPTH);
    assign out_valid_o = cnt_q != '0;
    assign out_data_o  = mem_q[rd_q];
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= in_data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/sample_scheduler.sv
// sample_scheduler: issues sample indices to the forward pass, replays them to the error
// fetcher in order, bounds samples in flight and counts retired deltas into epochs.
module sample_scheduler
    import sample_scheduler_pkg::*;
#(
    parameter int SAMPLE_ADDR_SIZE = 10,
    parameter int EPOCH_WIDTH      = 16,
    parameter int MAX_INFLIGHT     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [SAMPLE_ADDR_SIZE-1:0] last_index_i,
    input  logic [EPOCH_WIDTH-1:0]      epochs_i,
    output logic [SAMPLE_ADDR_SIZE-1:0] fwd_sample_index_o,
    output logic                        fwd_valid_o,
    input  logic                        fwd_ready_i,
    output logic [SAMPLE_ADDR_SIZE-1:0] err_sample_index_o,
    output logic                        err_valid_o,
    input  logic                        err_ready_i,
    input  logic                        delta_retire_i,
    input  logic                        error_in_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_flag_o,
    output logic [EPOCH_WIDTH-1:0]      epoch_count_o
);
    localparam int SA = SAMPLE_ADDR_SIZE;
    localparam int EW = EPOCH_WIDTH;
    localparam int CW = cnt_width(MAX_INFLIGHT);

    state_t        state_q, state_d;
    logic [SA-1:0] last_q, last_d, next_q, next_d, ret_q, ret_d;
    logic [EW-1:0] epochs_q, epochs_d, issued_q, issued_d, epoch_cnt_q, epoch_cnt_d;
    logic [CW-1:0] out_q, out_d;
    logic          fwd_valid_q, fwd_valid_d, busy_q, busy_d, done_q, done_d;
    logic          err_flag_q, err_flag_d;
    logic          fifo_ready, fwd_hs, retire;

    // Occupancy never exceeds outstanding, so the FIFO gate only guards a protocol breach.
    assign fwd_valid_o        = fwd_valid_q & fifo_ready;
    assign fwd_hs             = fwd_valid_o & fwd_ready_i;
    assign retire             = delta_retire_i & (out_q != '0);
    assign fwd_sample_index_o = next_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign error_flag_o       = err_flag_q;
    assign epoch_count_o      = epoch_cnt_q;

    index_fifo #(
        .WIDTH(SA),
        .DEPTH(MAX_INFLIGHT)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (fwd_hs),
        .in_ready_o (fifo_ready),
        .in_data_i  (next_q),
        .out_valid_o(err_valid_o),
        .out_ready_i(err_ready_i),
        .out_data_o (err_sample_index_o)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        epochs_d    = epochs_q;
        next_d      = next_q;
        issued_d    = issued_q;
        ret_d       = ret_q;
        epoch_cnt_d = epoch_cnt_q;
        out_d       = out_q + CW'(fwd_hs) - CW'(retire);
        err_flag_d  = err_flag_q | (error_in_i & (state_q != IDLE));
        if (retire) begin
            ret_d       = ret_q == last_q ? '0 : ret_q + SA'(1);
            epoch_cnt_d = epoch_cnt_q + EW'(ret_q == last_q);
        end
        if (fwd_hs) begin
            next_d   = next_q == last_q ? '0 : next_q + SA'(1);
            issued_d = issued_q + EW'(next_q == last_q);
        end
        case (state_q)
            IDLE: if (start_i) begin
                last_d      = last_index_i;
                epochs_d    = epochs_i;
                next_d      = '0;
                issued_d    = '0;
                ret_d       = '0;
                epoch_cnt_d = '0;
                err_flag_d  = 1'b0;
                state_d     = epochs_i == '0 ? DONE : ISSUE;
            end
            ISSUE: if (issued_d == epochs_q) state_d = DRAIN;
            DRAIN: if (out_q == '0 && !err_valid_o) state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
        fwd_valid_d = (state_d == ISSUE) && (out_d < CW'(MAX_INFLIGHT));
        busy_d      = (state_d == ISSUE) || (state_d == DRAIN);
        done_d      = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= '0;
            epochs_q    <= '0;
            next_q      <= '0;
            issued_q    <= '0;
            ret_q       <= '0;
            epoch_cnt_q <= '0;
            out_q       <= '0;
            fwd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            epochs_q    <= epochs_d;
            next_q      <= next_d;
            issued_q    <= issued_d;
            ret_q       <= ret_d;
            epoch_cnt_q <= epoch_cnt_d;
            out_q       <= out_d;
            fwd_valid_q <= fwd_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_flag_q  <= err_flag_d;
        end
    end

endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler: randomized bench checking sample_scheduler against a transaction-level
// model of issued, replayed and retired samples.
module tb_sample_scheduler;
    localparam int SA = 10;
    localparam int EW = 16;
    localparam int MI = 4;
    localparam int P_IDLE = 0, P_ISSUE = 1, P_DRAIN = 2, P_DONE = 3;

    logic          clk = 0, rst = 1, start = 0, fwd_ready = 0, err_ready = 0;
    logic          delta_retire = 0, error_in = 0;
    logic [SA-1:0] last_index = '0;
    logic [EW-1:0] epochs = '0;
    logic [SA-1:0] fwd_sample_index, err_sample_index;
    logic          fwd_valid, err_valid, busy, done, error_flag;
    logic [EW-1:0] epoch_count;

    always #5 clk = ~clk;

    sample_scheduler #(.SAMPLE_ADDR_SIZE(SA), .EPOCH_WIDTH(EW), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .rst(rst), .start_i(start), .last_index_i(last_index), .epochs_i(epochs),
        .fwd_sample_index_o(fwd_sample_index), .fwd_valid_o(fwd_valid), .fwd_ready_i(fwd_ready),
        .err_sample_index_o(err_sample_index), .err_valid_o(err_valid), .err_ready_i(err_ready),
        .delta_retire_i(delta_retire), .error_in_i(error_in), .busy_o(busy), .done_o(done),
        .error_flag_o(error_flag), .epoch_count_o(epoch_count)
    );

    int total_n = 0, bad_n = 0;
    int m_phase = P_IDLE, m_last = 0, m_epochs = 0, m_issued = 0, m_out = 0;
    int m_popped = 0, m_retired = 0;
    bit m_eflag = 0;
    int m_q[$];
    int pf = 100, pe = 100, pr = 100;
    int n_fwd = 0, n_err = 0, n_done = 0, f0 = 0, e0 = 0, d0 = 0, exp_n = 0, exp_ep = 0;
    bit ef_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_n++;
        if (got !== exp) begin
            bad_n++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_q.delete();
        m_issued = 0; m_out = 0; m_popped = 0; m_retired = 0; m_eflag = 0;
    endtask

    // Check outputs against the model, drive the next inputs, then advance the model one edge.
    task automatic cycle(input bit do_start, input bit do_rst, input bit inj_err);
        bit fv, fh, eh, rt, drained;
        @(negedge clk);
        fv = (m_phase == P_ISSUE) && (m_out < MI);
        check("fwd_valid", fwd_valid, fv);
        if (fv) check("fwd_index", fwd_sample_index, m_issued % (m_last + 1));
        check("err_valid", err_valid, m_q.size() != 0);
        if (m_q.size() != 0) check("err_index", err_sample_index, m_q[0]);
        check("busy", busy, m_phase == P_ISSUE || m_phase == P_DRAIN);
        check("done", done, m_phase == P_DONE);
        check("error_flag", error_flag, m_eflag);
        check("epoch_count", epoch_count, m_retired / (m_last + 1));
        if (done) begin n_done++; ef_done = error_flag; end
        rst = do_rst; start = do_start; error_in = inj_err;
        fwd_ready = $urandom_range(99) < pf;
        err_ready = $urandom_range(99) < pe;
        delta_retire = (m_popped > m_retired) && ($urandom_range(99) < pr);
        assert (!(delta_retire && m_out == 0)) else $error("FAIL retire with nothing outstanding");
        if (fwd_valid && fwd_ready) n_fwd++;
        if (err_valid && err_ready) n_err++;
        fh = fv && fwd_ready;
        eh = m_q.size() != 0 && err_ready;
        rt = delta_retire && m_out > 0;
        drained = m_out == 0 && m_q.size() == 0;
        if (do_rst) begin model_reset(); return; end
        if (inj_err && m_phase != P_IDLE) m_eflag = 1;
        if (eh) begin void'(m_q.pop_front()); m_popped++; end
        if (fh) begin m_q.push_back(m_issued % (m_last + 1)); m_issued++; m_out++; end
        if (rt) begin m_out--; m_retired++; end
        case (m_phase)
            P_IDLE: if (do_start) begin
                m_last = int'(last_index); m_epochs = int'(epochs);
                m_issued = 0; m_retired = 0; m_popped = 0; m_eflag = 0;
                m_phase = (epochs == 0) ? P_DONE : P_ISSUE;
            end
            P_ISSUE: if (m_issued == m_epochs * (m_last + 1)) m_phase = P_DRAIN;
            P_DRAIN: if (drained) m_phase = P_DONE;
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic start_run(input int last, input int ep);
        last_index = SA'(last); epochs = EW'(ep);
        exp_n = ep * (last + 1); exp_ep = ep;
        f0 = n_fwd; e0 = n_err; d0 = n_done;
        cycle(1, 0, 0);
    endtask

    task automatic end_run();
        pf = (pf == 0) ? 50 : pf; pe = (pe == 0) ? 50 : pe; pr = (pr == 0) ? 50 : pr;
        for (int n = 0; n < 3000 && m_phase != P_IDLE; n++) cycle(0, 0, 0);
        check("run_timeout", m_phase, P_IDLE);
        check("fwd_count", n_fwd - f0, exp_n);
        check("err_count", n_err - e0, exp_n);
        check("done_pulses", n_done - d0, 1);
        check("epochs_done", epoch_count, exp_ep);
        check("busy_end", busy, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        cycle(0, 0, 0);
        check("rst_fwd_index", fwd_sample_index, 0);
        check("rst_err_index", err_sample_index, 0);

        pf = 100; pe = 100; pr = 100;
        start_run(3, 2);
        end_run();

        pf = 100; pe = 100; pr = 0;
        start_run(9, 1);
        repeat (8) cycle(0, 0, 0);
        check("inflight_cap", n_fwd - f0, 4);
        pr = 100; cycle(0, 0, 0); pr = 0;
        repeat (5) cycle(0, 0, 0);
        check("one_more_issue", n_fwd - f0, 5);
        pr = 100;
        end_run();

        pf = 100; pe = 0; pr = 0;
        start_run(9, 1);
        repeat (10) cycle(0, 0, 0);
        check("err_hold_index", err_sample_index, 0);
        check("err_hold_valid", err_valid, 1);
        check("stall_fwd", n_fwd - f0, 4);
        pe = 100; pr = 100;
        end_run();

        start_run(5, 0);
        check("zero_no_busy", busy, 0);
        cycle(0, 0, 0);
        check("zero_done", done, 1);
        end_run();

        pf = 70; pe = 70; pr = 70;
        start_run(3, 2);
        repeat (4) cycle(0, 0, 0);
        cycle(0, 0, 1);
        end_run();
        check("eflag_at_done", ef_done, 1);
        start_run(1, 1);
        cycle(0, 0, 0);
        check("eflag_cleared", error_flag, 0);
        end_run();

        pf = 100; pe = 100; pr = 0;
        start_run(5, 2);
        for (int n = 0; n < 20 && m_out != 3; n++) cycle(0, 0, 0);
        check("three_outstanding", m_out, 3);
        d0 = n_done;
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        check("rst_busy", busy, 0);
        check("rst_fwd_valid", fwd_valid, 0);
        check("rst_err_valid", err_valid, 0);
        check("rst_no_done", n_done - d0, 0);
        pr = 100;
        start_run(2, 1);
        cycle(0, 0, 0);
        check("restart_index", fwd_sample_index, 0);
        end_run();

        for (int r = 0; r < 8; r++) begin
            pf = $urandom_range(95, 30); pe = $urandom_range(95, 30); pr = $urandom_range(95, 30);
            start_run($urandom_range(6), $urandom_range(3, 1));
            end_run();
        end

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule
